// File: rtl/hourglass_driver_if.sv
// Bundles the hourglass driver's job request and its turn/status outputs.
// master = job requester, slave = hourglass_driver.
interface hourglass_driver_if #(
   parameter int MSB = 13
);
   logic           start;
   logic [MSB:0]   target;
   logic           turnSmall;
   logic           turnLarge;
   logic           busy;
   logic           done;
   logic           unreachable;
   logic [MSB:0]   elapsed;

   modport master (
      output start, target,
      input  turnSmall, turnLarge, busy, done, unreachable, elapsed
   );

   modport slave (
      input  start, target,
      output turnSmall, turnLarge, busy, done, unreachable, elapsed
   );
endinterface

// File: rtl/hourglass_driver.sv
// Measures an interval in minutes using a 4-minute and a 7-minute hourglass.
// Each clock edge is one minute. Targets are decomposed as b large runs plus
// a small runs; targets 9, 10, 13 and 17 use overlapping-glass macros instead.
//
// state  | meaning
// IDLE   | waiting for start; target is captured here
// DECIDE | classify target, issue the first turn(s) of the job
// RUN_L  | large glass running from full; chains on the edge it empties
// RUN_S  | small glass running from full; chains on the edge it empties
// M9     | 9-minute macro (both, small@4, large@7, large@8, end@9)
// M10    | 10-minute macro (both, small@4, small@7, end@10)
// FINISH | done pulse is high; returns to IDLE
module hourglass_driver #(
   parameter int MSB   = 13,
   parameter int SMALL = 4,
   parameter int LARGE = 7
) (
   input  logic                 clock_i,
   input  logic                 reset_n_i,
   hourglass_driver_if.slave    hg_if
);

   localparam int W  = MSB + 1;
   localparam int WX = MSB + 2;

   typedef enum logic [2:0] {
      IDLE, DECIDE, RUN_L, RUN_S, M9, M10, FINISH
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      ts_q, ts_d;
   logic [2:0]      tl_q, tl_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [1:0]      nl_q, nl_d;
   logic [WX-1:0]   ns_q, ns_d;
   logic [W-1:0]    target_q, target_d;
   logic [W-1:0]    elapsed_q, elapsed_d;
   logic            turn_s_q, turn_l_q;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            unr_q, unr_d;

   logic            flip_s, flip_l, chain;
   logic [1:0]      nl_c;
   logic [WX-1:0]   ns_c;
   logic [2:0]      ts_dec, tl_dec;
   logic [WX-1:0]   t_x, b_x, seven_b, a_x;
   logic [1:0]      b;

   // Decomposition of the captured target: b = 3t mod 4, a = (t - 7b) / 4.
   // One extra bit keeps the subtraction from wrapping at the widest target.
   always_comb begin
      t_x     = WX'(target_q);
      b       = 2'(target_q[1:0] + {target_q[0], 1'b0});
      b_x     = WX'(b);
      seven_b = (b_x << 3) - b_x;
      a_x     = (t_x - seven_b) >> 2;
   end

   // Next-state, glass tops and output pulses.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      nl_d      = nl_q;
      ns_d      = ns_q;
      target_d  = target_q;
      elapsed_d = elapsed_q;
      flip_s    = 1'b0;
      flip_l    = 1'b0;
      done_d    = 1'b0;
      unr_d     = 1'b0;
      chain     = 1'b0;
      nl_c      = nl_q;
      ns_c      = ns_q;

      ts_dec = (ts_q != 3'd0) ? ts_q - 3'd1 : ts_q;
      tl_dec = (tl_q != 3'd0) ? tl_q - 3'd1 : tl_q;

      case (state_q)
         IDLE: begin
            if (hg_if.start) begin
               target_d  = hg_if.target;
               elapsed_d = '0;
               state_d   = DECIDE;
            end
         end
         DECIDE: begin
            if (target_q == W'(0)) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end else if (target_q == W'(1) || target_q == W'(2) || target_q == W'(3) ||
                         target_q == W'(5) || target_q == W'(6)) begin
               state_d = IDLE;
               unr_d   = 1'b1;
            end else if (target_q == W'(9) || target_q == W'(13)) begin
               state_d = M9;
               flip_s  = 1'b1;
               flip_l  = 1'b1;
               cnt_d   = 4'd1;
               nl_d    = 2'd0;
               ns_d    = (target_q == W'(13)) ? WX'(1) : WX'(0);
            end else if (target_q == W'(10) || target_q == W'(17)) begin
               state_d = M10;
               flip_s  = 1'b1;
               flip_l  = 1'b1;
               cnt_d   = 4'd1;
               nl_d    = (target_q == W'(17)) ? 2'd1 : 2'd0;
               ns_d    = '0;
            end else begin
               chain = 1'b1;
               nl_c  = b;
               ns_c  = a_x;
            end
         end
         RUN_L: begin
            elapsed_d = elapsed_q + W'(1);
            chain     = (tl_q == 3'd1);
         end
         RUN_S: begin
            elapsed_d = elapsed_q + W'(1);
            chain     = (ts_q == 3'd1);
         end
         M9: begin
            elapsed_d = elapsed_q + W'(1);
            cnt_d     = cnt_q + 4'd1;
            flip_s    = (cnt_q == 4'd4);
            flip_l    = (cnt_q == 4'd7) || (cnt_q == 4'd8);
            chain     = (cnt_q == 4'd9);
         end
         M10: begin
            elapsed_d = elapsed_q + W'(1);
            cnt_d     = cnt_q + 4'd1;
            flip_s    = (cnt_q == 4'd4) || (cnt_q == 4'd7);
            chain     = (cnt_q == 4'd10);
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Start the next queued run on the edge the previous segment empties;
      // large runs are always drained before small ones.
      if (chain) begin
         if (nl_c != 2'd0) begin
            flip_l  = 1'b1;
            nl_d    = nl_c - 2'd1;
            ns_d    = ns_c;
            state_d = RUN_L;
         end else if (ns_c != WX'(0)) begin
            flip_s  = 1'b1;
            nl_d    = nl_c;
            ns_d    = ns_c - WX'(1);
            state_d = RUN_S;
         end else begin
            nl_d    = nl_c;
            ns_d    = ns_c;
            done_d  = 1'b1;
            state_d = FINISH;
         end
      end

      ts_d   = flip_s ? (3'(SMALL) - ts_dec) : ts_dec;
      tl_d   = flip_l ? (3'(LARGE) - tl_dec) : tl_dec;
      busy_d = (state_d != IDLE) || unr_d;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         ts_q      <= '0;
         tl_q      <= '0;
         cnt_q     <= '0;
         nl_q      <= '0;
         ns_q      <= '0;
         target_q  <= '0;
         elapsed_q <= '0;
         turn_s_q  <= 1'b0;
         turn_l_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         unr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ts_q      <= ts_d;
         tl_q      <= tl_d;
         cnt_q     <= cnt_d;
         nl_q      <= nl_d;
         ns_q      <= ns_d;
         target_q  <= target_d;
         elapsed_q <= elapsed_d;
         turn_s_q  <= flip_s;
         turn_l_q  <= flip_l;
         busy_q    <= busy_d;
         done_q    <= done_d;
         unr_q     <= unr_d;
      end
   end

   assign hg_if.turnSmall   = turn_s_q;
   assign hg_if.turnLarge   = turn_l_q;
   assign hg_if.busy        = busy_q;
   assign hg_if.done        = done_q;
   assign hg_if.unreachable = unr_q;
   assign hg_if.elapsed     = elapsed_q;

endmodule

// File: tb/tb_hourglass_driver.sv
// Directed bench for hourglass_driver. Each job records per-cycle pulse masks
// (bit k = output high in the k-th cycle after start capture; k=1 is the
// first-turn cycle) and compares them with hand-derived turn schedules.
module tb_hourglass_driver;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [63:0] s_mask, l_mask, d_mask, u_mask, b_mask;
   int          done_idx, el_done, n_s, n_l, n_u, el_last, last_out;

   hourglass_driver_if #(.MSB(13)) hg_if ();

   hourglass_driver #(.MSB(13), .SMALL(4), .LARGE(7)) dut (
      .clock_i   (clk),
      .reset_n_i (rst_n),
      .hg_if     (hg_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: request a job, then sample ncyc cycles at negedges.
   task automatic run_job(input int tgt, input int ncyc, input int mid_k, input int rst_k);
      s_mask = '0; l_mask = '0; d_mask = '0; u_mask = '0; b_mask = '0;
      done_idx = -1; el_done = -1; n_s = 0; n_l = 0; n_u = 0;
      hg_if.start  = 1'b1;
      hg_if.target = 14'(tgt);
      @(negedge clk);
      hg_if.start = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         if (k < 64) begin
            s_mask[k] = hg_if.turnSmall;
            l_mask[k] = hg_if.turnLarge;
            d_mask[k] = hg_if.done;
            u_mask[k] = hg_if.unreachable;
            b_mask[k] = hg_if.busy;
         end
         if (hg_if.turnSmall)   n_s++;
         if (hg_if.turnLarge)   n_l++;
         if (hg_if.unreachable) n_u++;
         if (hg_if.done && done_idx < 0) begin
            done_idx = k;
            el_done  = int'(hg_if.elapsed);
         end
         el_last  = int'(hg_if.elapsed);
         last_out = int'({hg_if.turnSmall, hg_if.turnLarge, hg_if.busy,
                          hg_if.done, hg_if.unreachable});
         hg_if.start  = (k == mid_k);
         if (k == mid_k) hg_if.target = 14'd4;
         if (k == rst_k) rst_n = 1'b0;
         @(negedge clk);
      end
      hg_if.start = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      hg_if.start = 1'b0;
      hg_if.target = '0;
      repeat (3) @(negedge clk);

      chk("rst_turnSmall", 64'(hg_if.turnSmall), 64'd0);
      chk("rst_turnLarge", 64'(hg_if.turnLarge), 64'd0);
      chk("rst_busy",      64'(hg_if.busy),      64'd0);
      chk("rst_done",      64'(hg_if.done),      64'd0);
      chk("rst_unreach",   64'(hg_if.unreachable), 64'd0);
      chk("rst_elapsed",   64'(hg_if.elapsed),   64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_job(4, 8, -1, -1);
      chk("t4_small", s_mask, 64'h2);
      chk("t4_large", l_mask, 64'h0);
      chk("t4_done",  d_mask, 64'h20);
      chk("t4_elap",  64'(el_done), 64'd4);
      chk("t4_busy",  b_mask, 64'h3F);

      run_job(9, 12, -1, -1);
      chk("t9_small", s_mask, 64'h22);
      chk("t9_large", l_mask, 64'h302);
      chk("t9_done",  d_mask, 64'h400);
      chk("t9_elap",  64'(el_done), 64'd9);
      chk("t9_busy",  b_mask, 64'h7FF);

      run_job(17, 20, -1, -1);
      chk("t17_small", s_mask, 64'h122);
      chk("t17_large", l_mask, 64'h802);
      chk("t17_done",  d_mask, 64'h40000);
      chk("t17_elap",  64'(el_done), 64'd17);

      run_job(25, 28, -1, -1);
      chk("t25_small", s_mask, 64'h400000);
      chk("t25_large", l_mask, 64'h8102);
      chk("t25_done",  d_mask, 64'h4000000);
      chk("t25_elap",  64'(el_done), 64'd25);
      chk("t25_busy",  b_mask, 64'h7FFFFFF);

      run_job(13, 16, -1, -1);
      chk("t13_small", s_mask, 64'h422);
      chk("t13_large", l_mask, 64'h302);
      chk("t13_done",  d_mask, 64'h4000);

      run_job(5, 4, -1, -1);
      chk("t5_unreach", u_mask, 64'h2);
      chk("t5_done",    d_mask, 64'h0);
      chk("t5_turns",   s_mask | l_mask, 64'h0);
      chk("t5_busy",    b_mask, 64'h3);

      run_job(0, 4, -1, -1);
      chk("t0_done",    d_mask, 64'h2);
      chk("t0_unreach", u_mask, 64'h0);
      chk("t0_turns",   s_mask | l_mask, 64'h0);
      chk("t0_elap",    64'(el_done), 64'd0);

      run_job(3, 4, -1, -1);
      chk("t3_unreach", u_mask, 64'h2);
      chk("t3_done",    d_mask, 64'h0);
      chk("t3_turns",   s_mask | l_mask, 64'h0);

      run_job(7, 10, -1, -1);
      chk("t7_large", l_mask, 64'h2);
      chk("t7_small", s_mask, 64'h0);
      chk("t7_done",  d_mask, 64'h100);

      run_job(14, 17, -1, -1);
      chk("t14_large", l_mask, 64'h102);
      chk("t14_done",  d_mask, 64'h8000);

      run_job(11, 14, -1, -1);
      chk("t11_large", l_mask, 64'h2);
      chk("t11_small", s_mask, 64'h100);
      chk("t11_done",  d_mask, 64'h1000);

      run_job(8, 12, 3, -1);
      chk("t8mid_small", s_mask, 64'h22);
      chk("t8mid_large", l_mask, 64'h0);
      chk("t8mid_done",  d_mask, 64'h200);
      chk("t8mid_elap",  64'(el_done), 64'd8);
      chk("t8mid_busy",  b_mask, 64'h3FF);

      run_job(8, 8, -1, 3);
      chk("t8rst_small", s_mask, 64'h2);
      chk("t8rst_done",  d_mask, 64'h0);
      chk("t8rst_busy",  b_mask, 64'hF);
      chk("t8rst_outs",  64'(last_out), 64'd0);
      chk("t8rst_elap",  64'(el_last), 64'd0);

      rst_n = 1'b1;
      run_job(4, 8, -1, -1);
      chk("rel_small", s_mask, 64'h2);
      chk("rel_done",  d_mask, 64'h20);
      chk("rel_elap",  64'(el_done), 64'd4);

      run_job(16383, 16390, -1, -1);
      chk("tmax_done_idx", 64'(done_idx), 64'd16384);
      chk("tmax_elap",     64'(el_done),  64'd16383);
      chk("tmax_nlarge",   64'(n_l),      64'd1);
      chk("tmax_nsmall",   64'(n_s),      64'd4094);
      chk("tmax_unreach",  64'(n_u),      64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
